// File: rtl/gshare_bht.sv
// Gshare/bimodal branch history table with saturating counters, speculative GHR and sweep init.
// Define BHT_GSHARE_EN to hash the GHR into the index; otherwise the index is pc_idx (bimodal).
module gshare_bht #(
    parameter int width    = 10,
    parameter int hist_len = 10,
    parameter int ctr_bits = 2,
    parameter int init_ctr = 2**(ctr_bits-1)-1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read,
    input  logic [width-1:0]    pc_idx,
    output logic                prediction,
    output logic [width-1:0]    pred_idx,
    output logic [hist_len-1:0] pred_ghr,
    output logic                ready,
    input  logic                load,
    input  logic [width-1:0]    w_idx,
    input  logic                taken,
    input  logic                mispredict,
    input  logic [hist_len-1:0] upd_ghr
);

    localparam int n_sets = 2**width;
    localparam logic [ctr_bits-1:0] INIT_VAL = ctr_bits'(init_ctr);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q;
    logic [width-1:0]    sweep_q;
    logic                ready_q;
    logic [hist_len-1:0] ghr_q;
    logic [hist_len-1:0] ghr_d;
    logic [ctr_bits-1:0] table_q [n_sets];

    logic                read_en;
    logic                load_en;
    logic [width-1:0]    hash_idx;
    logic                rd_msb;
    logic [ctr_bits-1:0] upd_cur;
    logic [ctr_bits-1:0] upd_nxt;
    logic                fwd;
    logic [hist_len-1:0] ghr_repair;
    logic [hist_len-1:0] ghr_spec;

    // Sweep FSM: one entry per cycle, ready registered alongside the RUN transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == '1) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign read_en = read && ready_q;
    assign load_en = load && ready_q;

`ifdef BHT_GSHARE_EN
    logic [width-1:0] ghr_ext;
    always_comb begin
        ghr_ext                = '0;
        ghr_ext[hist_len-1:0]  = ghr_q;
    end
    assign hash_idx = pc_idx ^ ghr_ext;
`else
    assign hash_idx = pc_idx;
`endif

    assign pred_idx = hash_idx;
    assign pred_ghr = ghr_q;

    always_comb begin
        upd_cur = table_q[w_idx];
        upd_nxt = upd_cur;
        if (taken) begin
            if (upd_cur != '1) upd_nxt = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
        end
    end

    // A same-cycle update to the entry being read is forwarded so the fetch sees the resolved state.
    assign rd_msb     = table_q[hash_idx][ctr_bits-1];
    assign fwd        = load_en && (w_idx == hash_idx);
    assign prediction = read_en && (fwd ? upd_nxt[ctr_bits-1] : rd_msb);

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            table_q[sweep_q] <= INIT_VAL;
        end else if (load_en) begin
            table_q[w_idx] <= upd_nxt;
        end
    end

    generate
        if (hist_len == 1) begin : g_hist_one
            logic unused_upd;
            assign unused_upd = ^upd_ghr;
            assign ghr_repair = taken;
            assign ghr_spec   = prediction;
        end else begin : g_hist_many
            logic unused_upd;
            assign unused_upd = upd_ghr[hist_len-1];
            assign ghr_repair = {upd_ghr[hist_len-2:0], taken};
            assign ghr_spec   = {ghr_q[hist_len-2:0], prediction};
        end
    endgenerate

    // Repair wins over a speculative shift in the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (load_en && mispredict) begin
            ghr_d = ghr_repair;
        end else if (read_en) begin
            ghr_d = ghr_spec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

endmodule

// File: tb/tb_gshare_bht.sv
// Scoreboard bench for gshare_bht: directed vectors push expected {prediction, pred_idx, pred_ghr}; a negedge monitor pops and compares.
module tb_gshare_bht;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int EW = 1 + W + H;
`ifdef BHT_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         read = 1'b0;
  logic [W-1:0] pc_idx = '0;
  logic         prediction;
  logic [W-1:0] pred_idx;
  logic [H-1:0] pred_ghr;
  logic         ready;
  logic         load = 1'b0;
  logic [W-1:0] w_idx = '0;
  logic         taken = 1'b0;
  logic         mispredict = 1'b0;
  logic [H-1:0] upd_ghr = '0;

  int checks = 0;
  int failures = 0;
  bit m_ready = 1'b0;
  logic [H-1:0] ghr_m = '0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  gshare_bht dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .pc_idx     (pc_idx),
    .prediction (prediction),
    .pred_idx   (pred_idx),
    .pred_ghr   (pred_ghr),
    .ready      (ready),
    .load       (load),
    .w_idx      (w_idx),
    .taken      (taken),
    .mispredict (mispredict),
    .upd_ghr    (upd_ghr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // monitor: a read accepted while the model says ready must match the queue head
  always @(negedge clk) begin
    if (m_ready && read) begin
      checks++;
      if (!ready) begin
        failures++;
        $display("FAIL mon_ready: got ready=%0b expected 1", ready);
        if (exp_q.size() != 0) mon_e = exp_q.pop_front();
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mon_unexpected: got pred=%0b idx=%h ghr=%h with empty queue", prediction, pred_idx, pred_ghr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({prediction, pred_idx, pred_ghr} !== mon_e) begin
          failures++;
          $display("FAIL mon_output: got pred=%0b idx=%h ghr=%h expected pred=%0b idx=%h ghr=%h",
                   prediction, pred_idx, pred_ghr, mon_e[EW-1], mon_e[W+H-1:H], mon_e[H-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pc_of(input logic [W-1:0] tgt);
    return GS ? (tgt ^ ghr_m) : tgt;
  endfunction

  // driver: call at posedge+1; drives one cycle and advances the history model
  task automatic apply(input bit rd, input logic [W-1:0] pc, input bit ld, input logic [W-1:0] wi,
                       input bit tk, input bit mp, input logic [H-1:0] ug,
                       input bit e_p, input logic [W-1:0] e_idx, input logic [H-1:0] e_ghr);
    read = rd; pc_idx = pc; load = ld; w_idx = wi; taken = tk; mispredict = mp; upd_ghr = ug;
    if (rd && m_ready) exp_q.push_back({e_p, e_idx, e_ghr});
    @(posedge clk);
    if (ld && m_ready && mp) ghr_m = {ug[H-2:0], tk};
    else if (rd && m_ready) ghr_m = {ghr_m[H-2:0], e_p};
    #1;
    read = 1'b0; load = 1'b0; mispredict = 1'b0;
  endtask

  task automatic rd_tgt(input logic [W-1:0] tgt, input bit p);
    apply(1'b1, pc_of(tgt), 1'b0, '0, 1'b0, 1'b0, '0, p, tgt, ghr_m);
  endtask

  task automatic ld(input logic [W-1:0] wi, input bit tk);
    apply(1'b0, '0, 1'b1, wi, tk, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic ld_rd(input logic [W-1:0] wi, input bit tk, input logic [W-1:0] tgt, input bit p);
    apply(1'b1, pc_of(tgt), 1'b1, wi, tk, 1'b0, '0, p, tgt, ghr_m);
  endtask

  // Called at posedge+1 right after rst deasserts; drives hostile traffic that INIT must ignore.
  task automatic do_init();
    int seen;
    int bad;
    seen = 0;
    bad = 0;
    m_ready = 1'b0;
    for (int cyc = 1; cyc <= 1100 && seen == 0; cyc++) begin
      read = 1'b1; pc_idx = W'(cyc * 37);
      load = 1'b1; w_idx = W'(cyc >> 1); taken = 1'b1; mispredict = 1'b1; upd_ghr = '1;
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = cyc;
        read = 1'b0; load = 1'b0; mispredict = 1'b0;
      end else if (prediction !== 1'b0 || pred_ghr !== '0) begin
        bad++;
      end
      @(posedge clk);
      #1;
    end
    read = 1'b0; load = 1'b0; mispredict = 1'b0;
    chk("init_ready_cycle", seen, 1025);
    chk("init_outputs_nonzero_cycles", bad, 0);
    ghr_m = '0;
    m_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    do_init();

    // every entry holds weakly not-taken; reads of 0 keep the history at zero
    for (int i = 0; i < 1024; i++) rd_tgt(W'(i), 1'b0);

    // saturation at entry 5
    ld(10'd5, 1'b1); ld(10'd5, 1'b1); ld(10'd5, 1'b1);
    rd_tgt(10'd5, 1'b1);
    ld(10'd5, 1'b0);
    rd_tgt(10'd5, 1'b1);
    ld(10'd5, 1'b0); ld(10'd5, 1'b0); ld(10'd5, 1'b0);
    rd_tgt(10'd5, 1'b0);
    ld(10'd5, 1'b1);
    rd_tgt(10'd5, 1'b0);
    ld(10'd5, 1'b1);
    rd_tgt(10'd5, 1'b1);

    // forwarding
    ld_rd(10'd7, 1'b1, 10'd7, 1'b1);
    rd_tgt(10'd7, 1'b1);
    ld(10'd9, 1'b1);
    ld_rd(10'd9, 1'b0, 10'd9, 1'b0);
    rd_tgt(10'd9, 1'b0);
    ld_rd(10'd12, 1'b1, 10'd11, 1'b0);
    rd_tgt(10'd12, 1'b1);
    rd_tgt(10'd11, 1'b0);

    // asynchronous reset while running with a non-zero history
    m_ready = 1'b0;
    @(negedge clk);
    #2;
    read = 1'b1; pc_idx = 10'd5; rst = 1'b1;
    #1;
    chk("async_rst_run_ready", ready, 0);
    chk("async_rst_run_ghr", pred_ghr, 0);
    chk("async_rst_run_pred", prediction, 0);
    read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset at sweep cycle 500
    read = 1'b1;
    repeat (499) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sweep_ready", ready, 0);
    chk("async_rst_sweep_pred", prediction, 0);
    read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_init();

    // speculative history: predictions 1,0,1 build ghr=0x005
    ld(10'h020, 1'b1);
    ld(10'h040, 1'b1);
    rd_tgt(10'h020, 1'b1);
    rd_tgt(10'h030, 1'b0);
    rd_tgt(10'h040, 1'b1);
    apply(1'b1, 10'h00F, 1'b0, '0, 1'b0, 1'b0, '0,
          1'b0, (GS ? 10'h00A : 10'h00F), 10'h005);

    // repair beats a same-cycle speculative shift of 1
    apply(1'b1, pc_of(10'h020), 1'b1, 10'h050, 1'b0, 1'b1, 10'h003,
          1'b1, 10'h020, ghr_m);
    apply(1'b1, (GS ? (10'h060 ^ 10'h006) : 10'h060), 1'b0, '0, 1'b0, 1'b0, '0,
          1'b0, 10'h060, 10'h006);
    ld(10'h050, 1'b1);
    rd_tgt(10'h050, 1'b0);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
